// File: rtl/seg_shift_out.sv
// -----------------------------------------------------------------------------
// seg_shift_out
//   Serialises a packed 7-segment pattern word onto a 74HC595-style chain.
//   A frame is accepted on valid && ready. It is shifted out MSB first, one bit
//   per 2*CLK_DIV clocks, and then latched with a CLK_DIV-cycle storage pulse.
//   done pulses for one cycle when the new pattern is on the display.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   seg_in     pattern word, upper byte = first digit
//   valid      seg_in valid; accepted when valid && ready
//   ready      idle, able to accept a frame (decode of IDLE)
//   ser_data   serial data to the chain, stable for the whole bit period
//   ser_clk    shift clock; the chain samples ser_data on its rising edge
//   ser_latch  storage-register latch pulse, active high
//   done       one-cycle pulse in the first IDLE cycle after the latch
// -----------------------------------------------------------------------------
module seg_shift_out #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seg_in,
  input  logic             valid,
  output logic             ready,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             done
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;

  // The divider counts across a whole bit period (0 .. 2*CLK_DIV-1). DW bits
  // hold that range for every CLK_DIV >= 1.
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BITS     = BW'(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_latch_q, ser_latch_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sr_shl;

  assign sr_shl = sr_q << 1;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    ser_data_d  = ser_data_q;
    ser_clk_d   = ser_clk_q;
    ser_latch_d = ser_latch_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          sr_d       = seg_in;
          bit_cnt_d  = BITS;
          div_d      = '0;
          ser_data_d = seg_in[WIDTH-1];
          ser_clk_d  = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DIV_END) begin
          // End of the high phase: drop the clock and present the next bit
          // in the same edge, so data never moves while ser_clk is high.
          ser_clk_d = 1'b0;
          div_d     = '0;
          sr_d      = sr_shl;
          bit_cnt_d = bit_cnt_q - LAST_BIT;
          if (bit_cnt_q == LAST_BIT) begin
            ser_data_d  = 1'b0;
            ser_latch_d = 1'b1;
            state_d     = LATCH;
          end else begin
            ser_data_d = sr_shl[WIDTH-1];
          end
        end else begin
          if (div_q == DIV_HALF) ser_clk_d = 1'b1;
          div_d = div_q + DW'(1);
        end
      end

      LATCH: begin
        if (div_q == DIV_HALF) begin
          ser_latch_d = 1'b0;
          div_d       = '0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        ser_data_d  = 1'b0;
        ser_clk_d   = 1'b0;
        ser_latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
      done_q      <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign ser_latch = ser_latch_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg_shift_out.sv
// -----------------------------------------------------------------------------
// tb_seg_shift_out
//   Bench for seg_shift_out. Instance a uses the defaults (WIDTH=16,
//   CLK_DIV=4). Instance b uses WIDTH=8, CLK_DIV=1. The reference is the
//   frame-level behaviour: the bits seen at ser_clk rises must spell the word
//   MSB first; latch starts right after 2*CLK_DIV*WIDTH shift cycles and lasts
//   CLK_DIV cycles; done arrives 2*CLK_DIV*WIDTH+CLK_DIV+1 cycles after accept.
// -----------------------------------------------------------------------------
module tb_seg_shift_out;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] seg_a = '0;
  logic        val_a = 1'b0;
  logic        rdy_a, sd_a, sc_a, sl_a, dn_a;
  logic [7:0]  seg_b = '0;
  logic        val_b = 1'b0;
  logic        rdy_b, sd_b, sc_b, sl_b, dn_b;

  int n_cmp  = 0;
  int n_fail = 0;

  seg_shift_out #(.WIDTH(16), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .seg_in(seg_a), .valid(val_a), .ready(rdy_a),
    .ser_data(sd_a), .ser_clk(sc_a), .ser_latch(sl_a), .done(dn_a));

  seg_shift_out #(.WIDTH(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .seg_in(seg_b), .valid(val_b), .ready(rdy_b),
    .ser_data(sd_b), .ser_clk(sc_b), .ser_latch(sl_b), .done(dn_b));

  // Present one frame: wait for ready, raise valid so the next posedge
  // accepts it, then drop valid unless hold is set.
  task automatic accept(input int sel, input logic [15:0] w, input bit hold);
    int i;
    i = 0;
    while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (i >= 400) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: ready still low after %0d cycles, required 1", i);
    end
    @(negedge clk);
    if (sel == 0) begin seg_a = w; val_a = 1'b1; end
    else begin seg_b = w[7:0]; val_b = 1'b1; end
    @(posedge clk);
    #1;
    if (!hold) begin val_a = 1'b0; val_b = 1'b0; end
  endtask

  // Observe one frame from just after the accept edge until done. This only
  // measures; every test compares the numbers against its own expectation.
  // inj_n != 0 pulses valid on instance a with inj_word at that cycle.
  task automatic run_frame(input int sel, input int w, input int cd,
                           input int inj_n, input logic [15:0] inj_word,
                           output logic [31:0] cap, output int rises,
                           output int lat_cyc, output int lat_start,
                           output int lat_pulses, output int done_n,
                           output int rdy_low, output int unstable);
    logic pc, pd, pl, c, d, l, r, dn;
    int bound, n;
    bit fin;
    cap = '0; rises = 0; lat_cyc = 0; lat_start = 0; lat_pulses = 0;
    done_n = 0; rdy_low = 0; unstable = 0;
    pc = 1'b0; pd = 1'b0; pl = 1'b0; fin = 1'b0;
    bound = 2 * cd * w + cd + 20;
    n = 0;
    while (!fin && n < bound) begin
      @(negedge clk);
      n++;
      if (sel == 0) begin c = sc_a; d = sd_a; l = sl_a; r = rdy_a; dn = dn_a; end
      else begin c = sc_b; d = sd_b; l = sl_b; r = rdy_b; dn = dn_b; end
      if (c && !pc) begin cap = {cap[30:0], d}; rises++; end
      // data may only move on the cycle ser_clk falls
      if (n > 1 && d !== pd && !(pc && !c)) unstable++;
      if (l) begin lat_cyc++; if (lat_start == 0) lat_start = n; end
      if (l && !pl) lat_pulses++;
      if (!r) rdy_low++;
      if (inj_n != 0 && n == inj_n) begin seg_a = inj_word; val_a = 1'b1; end
      if (inj_n != 0 && n == inj_n + 1) val_a = 1'b0;
      pc = c; pd = d; pl = l;
      if (dn === 1'b1) begin done_n = n; fin = 1'b1; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({sd_a, sc_a, sl_a, dn_a, rdy_a} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_a: got %b required 00001", {sd_a, sc_a, sl_a, dn_a, rdy_a});
    end
    n_cmp++;
    if ({sd_b, sc_b, sl_b, dn_b, rdy_b} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_b: got %b required 00001", {sd_b, sc_b, sl_b, dn_b, rdy_b});
    end
    rst = 1'b1;
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sc_a !== 1'b0 || sl_a !== 1'b0 || dn_a !== 1'b0 || rdy_a !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_fcfc;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us;
    logic [15:0] want;
    want = 16'b1111_1100_1111_1100;
    accept(0, 16'hFCFC, 1'b0);
    run_frame(0, 16, 4, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[15:0] !== want || ri !== 16) begin
      n_fail++; $display("FAIL fcfc_bits: got %h (%0d rises) required %h (16)", cap[15:0], ri, want);
    end
    n_cmp++;
    if (lc !== 4 || ls !== 129 || lp !== 1) begin
      n_fail++; $display("FAIL fcfc_latch: got len %0d start %0d pulses %0d required 4 129 1", lc, ls, lp);
    end
    n_cmp++;
    if (dn !== 133 || rl !== 132) begin
      n_fail++; $display("FAIL fcfc_timing: got done %0d ready_low %0d required 133 132", dn, rl);
    end
    n_cmp++;
    if (us !== 0) begin n_fail++; $display("FAIL fcfc_stable: got %0d data moves required 0", us); end
    n_cmp++;
    if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL fcfc_ready: got %b required 1", rdy_a); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us;
    accept(0, 16'h60DA, 1'b1);
    run_frame(0, 16, 4, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[15:0] !== 16'b0110_0000_1101_1010 || dn !== 133) begin
      n_fail++; $display("FAIL b2b_f1: got %h done %0d required 60da 133", cap[15:0], dn);
    end
    n_cmp++;
    if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b required 1", rdy_a); end
    seg_a = 16'hF266;          // valid still high: taken at this done cycle
    @(posedge clk);
    #1;
    val_a = 1'b0;
    run_frame(0, 16, 4, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[15:0] !== 16'b1111_0010_0110_0110 || ri !== 16) begin
      n_fail++; $display("FAIL b2b_f2_bits: got %h (%0d rises) required f266 (16)", cap[15:0], ri);
    end
    n_cmp++;
    if (dn !== 133 || rl !== 132 || lp !== 1) begin
      n_fail++; $display("FAIL b2b_f2_timing: got done %0d ready_low %0d latches %0d required 133 132 1", dn, rl, lp);
    end
  endtask

  task automatic test_ignore;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us, extra;
    accept(0, 16'hFCFC, 1'b0);
    run_frame(0, 16, 4, 40, 16'h0000, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[15:0] !== 16'hFCFC || dn !== 133) begin
      n_fail++; $display("FAIL ignore_bits: got %h done %0d required fcfc 133", cap[15:0], dn);
    end
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (dn_a !== 1'b0 || rdy_a !== 1'b1 || sc_a !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_fail++; $display("FAIL ignore_queued: got %0d busy cycles required 0", extra); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us, rises, bad, i;
    logic pc;
    accept(0, 16'hFFFF, 1'b0);
    rises = 0; pc = 1'b0; i = 0;
    while (rises < 7 && i < 200) begin
      @(negedge clk);
      i++;
      if (sc_a && !pc) rises++;
      pc = sc_a;
    end
    @(negedge clk);            // still in the high phase of bit 7
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({sd_a, sc_a, sl_a, dn_a, rdy_a} !== 5'b00001) begin
      n_fail++; $display("FAIL rstmid_async: got %b required 00001", {sd_a, sc_a, sl_a, dn_a, rdy_a});
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sl_a !== 1'b0 || dn_a !== 1'b0 || rdy_a !== 1'b1 || sc_a !== 1'b0) bad++;
    end
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sl_a !== 1'b0 || dn_a !== 1'b0 || rdy_a !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d bad cycles required 0", bad); end
    accept(0, 16'hB6B6, 1'b0);
    run_frame(0, 16, 4, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[15:0] !== 16'hB6B6 || ri !== 16 || dn !== 133 || lc !== 4) begin
      n_fail++; $display("FAIL rstmid_next: got %h rises %0d done %0d latch %0d required b6b6 16 133 4", cap[15:0], ri, dn, lc);
    end
  endtask

  task automatic test_div1;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us;
    accept(1, 16'h00E0, 1'b0);
    run_frame(1, 8, 1, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
    n_cmp++;
    if (cap[7:0] !== 8'b1110_0000 || ri !== 8) begin
      n_fail++; $display("FAIL div1_bits: got %h (%0d rises) required e0 (8)", cap[7:0], ri);
    end
    n_cmp++;
    if (lc !== 1 || ls !== 17 || lp !== 1) begin
      n_fail++; $display("FAIL div1_latch: got len %0d start %0d pulses %0d required 1 17 1", lc, ls, lp);
    end
    n_cmp++;
    if (rl !== 17 || dn !== 18 || us !== 0) begin
      n_fail++; $display("FAIL div1_timing: got ready_low %0d done %0d moves %0d required 17 18 0", rl, dn, us);
    end
  endtask

  task automatic test_random;
    logic [31:0] cap; int ri, lc, ls, lp, dn, rl, us;
    logic [15:0] w;
    for (int f = 0; f < 6; f++) begin
      w = 16'($urandom);
      accept(0, w, 1'b0);
      run_frame(0, 16, 4, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
      n_cmp++;
      if (cap[15:0] !== w || ri !== 16 || dn !== 2*4*16+4+1 || lc !== 4 || us !== 0) begin
        n_fail++; $display("FAIL rand_a[%0d]: got %h r%0d d%0d l%0d u%0d required %h r16 d133 l4 u0", f, cap[15:0], ri, dn, lc, us, w);
      end
    end
    for (int f = 0; f < 4; f++) begin
      w = {8'h00, 8'($urandom)};
      accept(1, w, 1'b0);
      run_frame(1, 8, 1, 0, 16'h0, cap, ri, lc, ls, lp, dn, rl, us);
      n_cmp++;
      if (cap[7:0] !== w[7:0] || ri !== 8 || dn !== 2*1*8+1+1 || lc !== 1) begin
        n_fail++; $display("FAIL rand_b[%0d]: got %h r%0d d%0d l%0d required %h r8 d18 l1", f, cap[7:0], ri, dn, lc, w[7:0]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    test_idle;
    test_fcfc;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    test_div1;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_shift_out.md
Name: seg_shift_out

Overview:
- Downstream stage of the board countdown/decoder logic.
- Takes the packed 7-segment pattern word (two 8-bit digit patterns, 16 bits) and serialises it onto a 74HC595-style chain: serial data, shift clock, storage latch.
- Uses a valid/ready handshake, accepting one frame at a time, and pulses done when the new pattern is latched onto the display.

Parameters:
WIDTH, 16, number of pattern bits per frame (>=1); MSB shifted first
CLK_DIV, 4, clk cycles per ser_clk half-period and per latch pulse (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
seg_in  input  WIDTH  segment pattern word (upper byte = first digit)
valid  input  1  seg_in is valid; frame accepted when valid && ready
ready  output  1  block idle, able to accept a frame
ser_data  output  1  serial data to shift register chain
ser_clk  output  1  shift clock; chain samples ser_data on rising edge
ser_latch  output  1  storage-register latch pulse, active high
done  output  1  one-cycle pulse: frame latched

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ser_data=0, ser_clk=0, ser_latch=0, done=0, ready=1; shift register, bit counter and divider counter cleared.
- ready is a decode of state==IDLE.
- All other outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE:
    - ready=1.
    - On a clk edge with valid=1: capture seg_in into the shift register, set bit counter=WIDTH, clear the divider counter, drive ser_data=seg_in[WIDTH-1], and go to SHIFT.
  - SHIFT (one bit every 2*CLK_DIV cycles):
    - ser_clk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
    - ser_data is stable for the whole bit period, including across the rising edge.
    - At the end of the high phase: ser_clk returns to 0, the shift register shifts left (zero fill), ser_data takes the next bit, and the bit counter decrements.
    - When the last bit's high phase ends: go to LATCH with ser_clk=0 and ser_data=0.
    - SHIFT lasts exactly 2*CLK_DIV*WIDTH cycles.
  - LATCH:
    - ser_latch=1 for exactly CLK_DIV cycles, then go to IDLE.
    - done=1 in the first IDLE cycle after LATCH (coincides with ready rising).
- Timing totals:
  - ready is low for exactly 2*CLK_DIV*WIDTH + CLK_DIV cycles per frame (132 for the defaults).
  - Exactly WIDTH ser_clk rising edges and one ser_latch pulse per frame.
- Handshake:
  - valid while ready=0 is ignored: not queued, and seg_in changes mid-frame have no effect.
  - Back-to-back operation: if valid=1 in the done cycle, the next frame is accepted in that same cycle. Inter-frame gap is 1 ready cycle.
- Reset mid-operation: outputs return to reset values immediately. The partial frame is discarded, and no ser_latch or done pulse is generated for it.
- Counters:
  - Divider counter width is clog2(CLK_DIV)+1.
  - Bit counter width is clog2(WIDTH)+1.
  - Neither counter wraps within a frame.
- CLK_DIV=1: ser_clk toggles every cycle and the latch pulse is 1 cycle.
- WIDTH=1: single-bit frame.

Test Plan:
1. Defaults, seg_in=16'hFCFC, one-cycle valid -> ser_data sampled at the 16 ser_clk rises = 1111_1100_1111_1100; ser_latch high for 4 cycles immediately after the last bit; done at accept+133 (ready low 132 cycles); ready back to 1.
2. valid held high with seg_in=16'h60DA, then 16'hF266 -> two frames with a single ready cycle between them; the done cycle of frame 1 is the accept cycle of frame 2; bitstreams 0110_0000_1101_1010 and 1111_0010_0110_0110.
3. Accept 16'hFCFC, then pulse valid with seg_in=16'h0000 at cycle 40 -> ignored; bitstream unchanged, only one done pulse.
4. Assert rst=0 mid-SHIFT (after 7 bits) for 3 cycles -> ser_clk/ser_data/ser_latch go to 0 asynchronously and ready=1; no latch pulse and no done; a following frame of 16'hB6B6 serialises correctly.
5. CLK_DIV=1, WIDTH=8, seg_in=8'hE0 -> ser_clk toggles every cycle, 8 rising edges carrying 1110_0000, 1-cycle latch, ready low 17 cycles.
6. Idle with valid=0 for 200 cycles after reset -> ser_clk=0, ser_latch=0, done=0, ready=1 throughout.
